// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (p0 = core, p1 = DMA/debug) with atomic lock states and registered load return.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; otherwise p0 has fixed priority.
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_p0_rvalid;
  logic              r_p1_rvalid;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;

  logic w_p0_gnt;
  logic w_p1_gnt;
  logic w_pick1;
  logic w_p0_load;
  logic w_p1_load;

`ifdef DMEM_ARB_RR_EN
  assign w_pick1 = (r_last_grant == 1'b0);
`else
  // last_grant is still tracked but never overrides p0 in this build
  assign w_pick1 = r_last_grant & 1'b0;
`endif

  always_comb begin
    w_p0_gnt = 1'b0;
    w_p1_gnt = 1'b0;
    if (rst_n) begin
      case (r_state)
        ARB: begin
          if (p0_req && p1_req) begin
            w_p1_gnt = w_pick1;
            w_p0_gnt = !w_pick1;
          end else begin
            w_p0_gnt = p0_req;
            w_p1_gnt = p1_req;
          end
        end
        LOCK0:   w_p0_gnt = p0_req;
        LOCK1:   w_p1_gnt = p1_req;
        default: ;
      endcase
    end
  end

  assign w_p0_load = w_p0_gnt && !p0_we;
  assign w_p1_load = w_p1_gnt && !p1_we;

  assign p0_gnt    = w_p0_gnt;
  assign p1_gnt    = w_p1_gnt;
  assign mem_rd    = w_p0_load || w_p1_load;
  assign mem_wr    = (w_p0_gnt && p0_we) || (w_p1_gnt && p1_we);
  assign mem_addr  = w_p0_gnt ? p0_addr  : (w_p1_gnt ? p1_addr  : '0);
  assign mem_wdata = w_p0_gnt ? p0_wdata : (w_p1_gnt ? p1_wdata : '0);

  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB;
      r_last_grant <= 1'b1;
      r_p0_rvalid  <= 1'b0;
      r_p1_rvalid  <= 1'b0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
    end else begin
      r_p0_rvalid <= w_p0_load;
      r_p1_rvalid <= w_p1_load;
      if (w_p0_load) r_p0_rdata <= mem_rdata;
      if (w_p1_load) r_p1_rdata <= mem_rdata;

      if (w_p0_gnt)      r_last_grant <= 1'b0;
      else if (w_p1_gnt) r_last_grant <= 1'b1;

      // A lock is released by a granted unlocked access or by the owner going idle
      case (r_state)
        ARB: begin
          if (w_p0_gnt && p0_lock)      r_state <= LOCK0;
          else if (w_p1_gnt && p1_lock) r_state <= LOCK1;
        end
        LOCK0:   if (!p0_req || !p0_lock) r_state <= ARB;
        LOCK1:   if (!p1_req || !p1_lock) r_state <= ARB;
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; expectations follow the build's DMEM_ARB_RR_EN setting.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p0_lock;
  logic [15:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rvalid;
  logic [15:0] p0_rdata;
  logic        p1_req, p1_we, p1_lock;
  logic [15:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [15:0] p1_rdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] ram [0:255];
  int checks;
  int errors;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr) ram[mem_addr[7:0]] <= mem_wdata;

  task automatic clear_inputs();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    p0_req = 1; p0_we = 0; p0_addr = 16'h0000;
    #12;
    checks++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL rst_p0_gnt got %b exp 0", p0_gnt); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd got %b exp 0", mem_rd); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_wr got %b exp 0", mem_wr); end
    checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b%b exp 00", p0_rvalid, p1_rvalid); end
    checks++; if (p0_rdata !== 16'h0000 || p1_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0000/0000", p0_rdata, p1_rdata); end
    tick();
    rst_n = 1;
    #3;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL rst_first_gnt got %b exp 1", p0_gnt); end
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rst_first_rd got %b exp 1", mem_rd); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_store_load();
    p0_req = 1; p0_we = 1; p0_addr = 16'h0010; p0_wdata = 16'hBEEF;
    #3;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL sl_st_gnt got %b exp 1", p0_gnt); end
    checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL sl_st_wr_rd got %b%b exp 10", mem_wr, mem_rd); end
    checks++; if (mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL sl_st_bus got %h/%h exp 0010/beef", mem_addr, mem_wdata); end
    tick();
    p0_we = 0;
    #3;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL sl_ld_gnt got %b exp 1", p0_gnt); end
    checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL sl_ld_rd_wr got %b%b exp 10", mem_rd, mem_wr); end
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL sl_st_no_rvalid got %b exp 0", p0_rvalid); end
    tick();
    clear_inputs();
    #3;
    checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("FAIL sl_rvalid got %b exp 1", p0_rvalid); end
    checks++; if (p0_rdata !== 16'hBEEF) begin errors++; $display("FAIL sl_rdata got %h exp beef", p0_rdata); end
    tick();
    #3;
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL sl_rvalid_pulse got %b exp 0", p0_rvalid); end
    checks++; if (p0_rdata !== 16'hBEEF) begin errors++; $display("FAIL sl_rdata_hold got %h exp beef", p0_rdata); end
  endtask

  task automatic test_conflict();
    logic exp0;
    tick();
    p1_req = 1; p1_we = 1; p1_addr = 16'h0040; p1_wdata = 16'h1111;
    #3;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL cf_solo_p1 got %b exp 1", p1_gnt); end
    for (int i = 0; i < 4; i++) begin
      tick();
      p0_req = 1; p0_we = 1; p0_addr = 16'h0050; p0_wdata = 16'h2222;
      p1_req = 1; p1_we = 1; p1_addr = 16'h0060; p1_wdata = 16'h3333;
      #3;
`ifdef DMEM_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      checks++; if (p0_gnt !== exp0 || p1_gnt !== !exp0) begin errors++; $display("FAIL cf_cycle%0d got p0=%b p1=%b exp p0=%b p1=%b", i, p0_gnt, p1_gnt, exp0, !exp0); end
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_lock();
    tick();
    p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 16'h0070; p1_wdata = 16'h4444;
    #3;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL lk_enter got %b exp 1", p1_gnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      p0_req = 1; p0_we = 1; p0_addr = 16'h0080; p0_wdata = 16'h5555;
      #3;
      checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1) begin errors++; $display("FAIL lk_hold%0d got p0=%b p1=%b exp p0=0 p1=1", i, p0_gnt, p1_gnt); end
    end
    tick();
    p1_lock = 0;
    #3;
    checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1) begin errors++; $display("FAIL lk_last got p0=%b p1=%b exp p0=0 p1=1", p0_gnt, p1_gnt); end
    tick();
    #3;
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL lk_release got p0=%b p1=%b exp p0=1 p1=0", p0_gnt, p1_gnt); end
    tick();
    clear_inputs();
  endtask

  task automatic test_idle();
    tick();
    p0_addr = 16'h1234; p0_wdata = 16'h5678; p1_addr = 16'h9ABC; p1_wdata = 16'hDEF0;
    #3;
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL id_enables got rd=%b wr=%b exp 0/0", mem_rd, mem_wr); end
    checks++; if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL id_bus got %h/%h exp 0000/0000", mem_addr, mem_wdata); end
    checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("FAIL id_gnt got %b%b exp 00", p0_gnt, p1_gnt); end
    tick();
    #3;
    checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL id_rvalid got %b%b exp 00", p0_rvalid, p1_rvalid); end
    clear_inputs();
  endtask

  task automatic test_reset_inflight();
    tick();
    p0_req = 1; p0_we = 0; p0_lock = 1; p0_addr = 16'h0020;
    #3;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL ri_gnt got %b exp 1", p0_gnt); end
    tick();
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 16'h5A5A) begin errors++; $display("FAIL ri_pre got %b/%h exp 1/5a5a", p0_rvalid, p0_rdata); end
    rst_n = 0;
    #1;
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL ri_rvalid got %b exp 0", p0_rvalid); end
    checks++; if (p0_rdata !== 16'h0000) begin errors++; $display("FAIL ri_rdata got %h exp 0000", p0_rdata); end
    tick();
    rst_n = 1;
    clear_inputs();
    p1_req = 1; p1_we = 1; p1_addr = 16'h0090; p1_wdata = 16'h6666;
    #3;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL ri_arb got p1_gnt=%b exp 1", p1_gnt); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    tick();
    p1_req = 1; p1_we = 0; p1_addr = 16'h0030;
    #3;
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL bb_p1_gnt got %b exp 1", p1_gnt); end
    tick();
    clear_inputs();
    p0_req = 1; p0_we = 1; p0_addr = 16'h0030; p0_wdata = 16'hCAFE;
    #3;
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL bb_p0_gnt got %b exp 1", p0_gnt); end
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 16'h1234) begin errors++; $display("FAIL bb_p1_load got %b/%h exp 1/1234", p1_rvalid, p1_rdata); end
    tick();
    clear_inputs();
    #3;
    checks++; if (p1_rdata !== 16'h1234 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL bb_hold got %b/%h exp 0/1234", p1_rvalid, p1_rdata); end
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL bb_store_rvalid got %b exp 0", p0_rvalid); end
    checks++; if (ram[8'h30] !== 16'hCAFE) begin errors++; $display("FAIL bb_ram got %h exp cafe", ram[8'h30]); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    ram[8'h20] = 16'h5A5A;
    ram[8'h30] = 16'h1234;
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_store_load();
    test_conflict();
    test_lock();
    test_idle();
    test_reset_inflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
